// File: rtl/mux_rr_nx1.sv
// N-to-1 registered mux with fixed-select or round-robin arbitration and a one-deep output register.
// Optional build macro MUX_RR_LOCK_EN adds packet locking through the in_last/out_last ports.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | output register holds no beat (out_valid=0)
// S_FULL  | output register holds a beat awaiting out_ready
module mux_rr_nx1 #(
   parameter  int N  = 8,
   parameter  int W  = 8,
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   input  logic [N-1:0]    in_valid,
   input  logic [N*W-1:0]  in_data,
   output logic [N-1:0]    in_ready,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
`ifdef MUX_RR_LOCK_EN
   input  logic [N-1:0]    in_last,
   output logic            out_last,
`endif
   output logic [SW-1:0]   out_chan
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t          r_state;
   logic [W-1:0]    r_data;
   logic [SW-1:0]   r_chan;
   logic [SW-1:0]   r_ptr;

   logic            w_free;
   logic            w_gnt_vld;
   logic [SW-1:0]   w_gnt;
   logic [SW-1:0]   w_idx;
   logic            w_en_ok;
   logic            w_accept;
   logic            w_last;
   logic            w_ptr_upd;

`ifdef MUX_RR_LOCK_EN
   logic            r_lock;
   logic [SW-1:0]   r_lock_chan;
   logic            r_last;
`endif

   assign out_valid = (r_state == S_FULL);
   assign out_data  = r_data;
   assign out_chan  = r_chan;
`ifdef MUX_RR_LOCK_EN
   assign out_last  = r_last;
`endif

   always_comb begin
      w_free    = ~out_valid | out_ready;
      w_gnt     = '0;
      w_gnt_vld = 1'b0;
      w_idx     = '0;
      if (mode) begin
         // Rotating search starting at r_ptr; N is a power of two so the add wraps naturally.
         for (int i = 0; i < N; i++) begin
            w_idx = r_ptr + SW'(i);
            if (!w_gnt_vld && in_valid[w_idx]) begin
               w_gnt     = w_idx;
               w_gnt_vld = 1'b1;
            end
         end
      end else begin
         w_gnt     = sel;
         w_gnt_vld = 1'b1;
      end
`ifdef MUX_RR_LOCK_EN
      if (r_lock) begin
         w_gnt     = r_lock_chan;
         w_gnt_vld = 1'b1;
      end
      w_last    = in_last[w_gnt];
`else
      w_last    = 1'b1;
`endif
      w_en_ok   = rst_n & w_free & en & w_gnt_vld;
      w_accept  = w_en_ok & in_valid[w_gnt];
      w_ptr_upd = w_accept & mode & w_last;
      in_ready  = w_en_ok ? ({{(N-1){1'b0}}, 1'b1} << w_gnt) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_data      <= '0;
         r_chan      <= '0;
         r_ptr       <= '0;
`ifdef MUX_RR_LOCK_EN
         r_lock      <= 1'b0;
         r_lock_chan <= '0;
         r_last      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) r_state <= S_FULL;
            S_FULL:  if (out_ready && !w_accept) r_state <= S_EMPTY;
            default: r_state <= S_EMPTY;
         endcase
         if (w_accept) begin
            r_data <= in_data[w_gnt*W +: W];
            r_chan <= w_gnt;
         end
         if (w_ptr_upd) r_ptr <= w_gnt + SW'(1);
`ifdef MUX_RR_LOCK_EN
         if (w_accept) begin
            r_lock      <= ~w_last;
            r_lock_chan <= w_gnt;
            r_last      <= w_last;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed self-checking bench for mux_rr_nx1 (N=8, W=8); the lock scenario runs when MUX_RR_LOCK_EN is defined.
module tb_mux_rr_nx1;

   logic        clk = 1'b0;
   logic        rst_n, en, mode, out_ready;
   logic [2:0]  sel;
   logic [7:0]  in_valid;
   logic [63:0] in_data;
   logic [7:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_chan;
`ifdef MUX_RR_LOCK_EN
   logic [7:0]  in_last;
   logic        out_last;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_rr_nx1 #(.N(8), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
`ifdef MUX_RR_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_chan  (out_chan)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd0;
      in_valid = 8'hFF; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h30 + 8'(k);
`ifdef MUX_RR_LOCK_EN
      in_last = 8'h00;
`endif
      tick(); tick();
      chk("rst_in_ready", 32'(in_ready), 32'h00);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_out_chan", 32'(out_chan), 32'h0);

      // fixed select on channel 5
      rst_n = 1'b1; sel = 3'd5; #1;
      chk("sel5_ready", 32'(in_ready), 32'h20);
      tick();
      for (int r = 0; r < 3; r++) begin
         chk("sel5_valid", 32'(out_valid), 32'h1);
         chk("sel5_chan", 32'(out_chan), 32'h5);
         chk("sel5_data", 32'(out_data), 32'h35);
         chk("sel5_ready_hold", 32'(in_ready), 32'h20);
         tick();
      end
      in_data[40 +: 8] = 8'h55;
      tick();
      chk("sel5_data_new", 32'(out_data), 32'h55);
      in_data[40 +: 8] = 8'h35;

      sel = 3'd2; #1;
      chk("sel2_ready", 32'(in_ready), 32'h04);
      chk("sel2_held_chan", 32'(out_chan), 32'h5);
      tick();
      chk("sel2_chan", 32'(out_chan), 32'h2);
      chk("sel2_data", 32'(out_data), 32'h32);

      in_valid = 8'hFB; #1;
      chk("sel2_ready_novalid", 32'(in_ready), 32'h04);
      tick();
      chk("sel2_novalid_drain", 32'(out_valid), 32'h0);

      // round robin from ptr=0 (mode 0 must not have moved it)
      mode = 1'b1; in_valid = 8'hFF; #1;
      for (int i = 0; i < 16; i++) begin
         chk("rr_ready", 32'(in_ready), 32'(8'h01 << (i % 8)));
         tick();
         chk("rr_valid", 32'(out_valid), 32'h1);
         chk("rr_chan", 32'(out_chan), 32'(i % 8));
         chk("rr_data", 32'(out_data), 32'(8'h30 + 8'(i % 8)));
      end

      // hold a channel 3 beat under back-pressure
      in_valid = 8'h08; #1;
      chk("bp_ready3", 32'(in_ready), 32'h08);
      tick();
      chk("bp_chan3", 32'(out_chan), 32'h3);
      out_ready = 1'b0; in_valid = 8'hFF; #1;
      for (int r = 0; r < 4; r++) begin
         chk("bp_ready0", 32'(in_ready), 32'h00);
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_chan", 32'(out_chan), 32'h3);
         chk("bp_data", 32'(out_data), 32'h33);
         tick();
      end
      out_ready = 1'b1; #1;
      chk("bp_release_ready", 32'(in_ready), 32'h10);
      tick();
      chk("bp_next_chan", 32'(out_chan), 32'h4);
      chk("bp_next_valid", 32'(out_valid), 32'h1);

      // drain with enable low
      en = 1'b0; #1;
      chk("en0_ready", 32'(in_ready), 32'h00);
      tick();
      chk("en0_valid", 32'(out_valid), 32'h0);
      chk("en0_ready_after", 32'(in_ready), 32'h00);

      // wrap-around: get ptr to 7, then only channel 0 valid
      en = 1'b1; in_valid = 8'h40; #1;
      chk("wrap_ready6", 32'(in_ready), 32'h40);
      tick();
      chk("wrap_chan6", 32'(out_chan), 32'h6);
      in_valid = 8'h01; #1;
      chk("wrap_ready0", 32'(in_ready), 32'h01);
      tick();
      chk("wrap_chan0", 32'(out_chan), 32'h0);
      in_valid = 8'h03; #1;
      chk("wrap_ptr1_ready", 32'(in_ready), 32'h02);
      tick();
      chk("wrap_ptr1_chan", 32'(out_chan), 32'h1);

      in_valid = 8'h00; #1;
      chk("nogrant_ready", 32'(in_ready), 32'h00);
      tick();
      chk("nogrant_valid", 32'(out_valid), 32'h0);

      // reset with a held beat and ptr=6
      in_valid = 8'h20; #1;
      chk("pre_rst_ready", 32'(in_ready), 32'h20);
      tick();
      chk("pre_rst_chan", 32'(out_chan), 32'h5);
      rst_n = 1'b0; in_valid = 8'hFF; #1;
      chk("mid_rst_ready", 32'(in_ready), 32'h00);
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'h0);
      chk("post_rst_chan", 32'(out_chan), 32'h0);
      chk("post_rst_data", 32'(out_data), 32'h00);
      rst_n = 1'b1; in_valid = 8'h41; #1;
      chk("post_rst_ready", 32'(in_ready), 32'h01);
      tick();
      chk("post_rst_grant", 32'(out_chan), 32'h0);
      chk("post_rst_gdata", 32'(out_data), 32'h30);

`ifdef MUX_RR_LOCK_EN
      in_valid = 8'h02; in_last = 8'hFF; #1;
      chk("lk_ready1", 32'(in_ready), 32'h02);
      tick();
      in_valid = 8'hFF; in_last = 8'h00; #1;
      chk("lk_ready2a", 32'(in_ready), 32'h04);
      tick();
      chk("lk_chan_a", 32'(out_chan), 32'h2);
      chk("lk_last_a", 32'(out_last), 32'h0);
      chk("lk_ready2b", 32'(in_ready), 32'h04);
      tick();
      chk("lk_chan_b", 32'(out_chan), 32'h2);
      in_last = 8'h04; #1;
      chk("lk_ready2c", 32'(in_ready), 32'h04);
      tick();
      chk("lk_chan_c", 32'(out_chan), 32'h2);
      chk("lk_last_c", 32'(out_last), 32'h1);
      in_last = 8'h00; #1;
      chk("lk_ready3", 32'(in_ready), 32'h08);
      tick();
      chk("lk_chan_d", 32'(out_chan), 32'h3);
      chk("lk_last_d", 32'(out_last), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_rr_nx1.md
MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

Interface
REQ-001 Parameter N, default 8: number of input channels, power of two, 2..16.
REQ-002 Parameter W, default 8: data width per channel, 1..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  global enable; 0 blocks new acceptance.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  log2(N)  channel index used when mode=0.
REQ-008 in_valid  input  N  per-channel data-valid; bit k belongs to channel k.
REQ-009 in_data  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-010 in_ready  output  N  per-channel accept; at most one bit high in any cycle.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_data  output  W  registered data of held beat.
REQ-013 out_chan  output  log2(N)  source channel index of held beat.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Transfer on input k occurs in a cycle where in_valid[k] and in_ready[k] are both 1; output transfer when out_valid and out_ready are both 1.
REQ-016 Output register SHALL be "free" when out_valid=0 or (out_valid=1 and out_ready=1); a new beat is accepted only when free and en=1.
REQ-017 mode=0: granted channel is sel; in_ready[sel] = free and en (independent of in_valid[sel]); all other in_ready bits 0.
REQ-018 mode=1: granted channel is the first k with in_valid[k]=1, searching from ptr upward modulo N; in_ready is 1 only for that k, only when free and en; no grant if no in_valid bit is set.
REQ-019 ptr (log2(N) bits) SHALL update to (k+1) mod N only on an accepted input transfer in mode=1; unchanged otherwise, including in mode=0.
REQ-020 Latency: beat accepted in cycle t SHALL appear on out_valid/out_data/out_chan in cycle t+1; sustained throughput one beat per cycle when out_ready=1.
REQ-021 Output state machine: EMPTY (out_valid=0) -> FULL on accept; FULL -> FULL on simultaneous drain+accept; FULL -> EMPTY on drain without accept; FULL holds out_data/out_chan stable while out_ready=0.
REQ-022 en=0 SHALL not block draining of a held beat; out_valid falls after drain.
REQ-023 Changes to mode or sel SHALL take effect on the next grant decision; a held beat is unaffected.
REQ-024 Wrap-around: with ptr=N-1 and only channel 0 valid, channel 0 SHALL be granted and ptr becomes 1.

Reset
REQ-025 On clk edge with rst_n=0: out_valid=0, out_data=0, out_chan=0, ptr=0, lock state cleared; any held beat is discarded.
REQ-026 During reset cycles in_ready SHALL be all 0; no transfer is counted on the reset edge.

Configuration
REQ-027 Macro MUX_RR_LOCK_EN: when defined, add ports in_last (input, N) and out_last (output, 1, registered with the beat).
REQ-028 With MUX_RR_LOCK_EN: after accepting a beat with in_last[k]=0 from channel k, grant SHALL stay locked to k (both modes, ignoring sel/ptr) until a beat with in_last[k]=1 is accepted; ptr updates only on that last beat.
REQ-029 Without MUX_RR_LOCK_EN: no in_last/out_last ports; every beat is arbitrated independently.

Verification
REQ-030 mode=0, sel=5, N=8, in_valid=8'hFF, out_ready=1 -> only in_ready[5]=1; out_chan=5 every cycle, out_data=channel 5 data one cycle later.
REQ-031 mode=1, ptr=0, in_valid=8'hFF held, out_ready=1 for 16 cycles -> out_chan sequence 0,1,...,7,0,...,7.
REQ-032 mode=1, beat from ch 3 held, out_ready=0 for 4 cycles -> out_data/out_chan constant, in_ready=0; out_ready=1 -> drain and next beat (ch 4 if valid) same cycle.
REQ-033 Beat held, en=0, out_ready=1 -> beat drains, out_valid=0 next cycle, in_ready=0 throughout.
REQ-034 rst_n=0 for one cycle with out_valid=1 and ptr=6 -> out_valid=0, ptr=0; next grant with in_valid=8'h41 goes to ch 0.
REQ-035 MUX_RR_LOCK_EN defined, mode=1, ch 2 sends 3 beats (in_last=0,0,1) with all channels valid -> out_chan=2,2,2 then 3.
